// File: rtl/ifu.sv
// ifu: instruction fetch unit; define IFU_DELAY_SLOT_EN for MIPS branch-delay-slot semantics
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] ra,
   output logic [31:0] pc,
   output logic [31:0] pc_link,
   output logic        addr_err,
   output logic [31:0] instr_cnt
);
   logic [31:0] pc_q, pc_d, cnt_q, cnt_d, pc_plus4, br_tgt, jmp_tgt, tgt;
   logic        err_q, err_d, redirect;
   assign pc_plus4 = pc_q + 32'd4;
   assign br_tgt   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign jmp_tgt  = {pc_plus4[31:28], imm26, 2'b00};
   assign redirect = npc_sel[1] | (npc_sel[0] & br_taken);
   assign tgt      = npc_sel == 2'b11 ? ra : npc_sel == 2'b10 ? jmp_tgt : br_tgt;
   assign cnt_d    = stall ? cnt_q : cnt_q + 32'd1;
`ifdef IFU_DELAY_SLOT_EN
   typedef enum logic {IDLE, SLOT} state_t;
   state_t      state_q, state_d;
   logic [31:0] tgt_q, tgt_d;
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      pc_d    = pc_q;
      err_d   = err_q;
      if (!stall && state_q == SLOT) begin
         pc_d    = tgt_q;
         tgt_d   = '0;
         state_d = IDLE;
      end else if (!stall) begin
         pc_d = pc_plus4;
         if (redirect) begin
            tgt_d   = {tgt[31:2], 2'b00};
            err_d   = err_q | (|tgt[1:0]);
            state_d = SLOT;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         tgt_q   <= '0;
         state_q <= IDLE;
      end else begin
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         tgt_q   <= tgt_d;
         state_q <= state_d;
      end
   end
   assign pc_link = pc_q + 32'd8;
`else
   logic [31:0] nxt;
   always_comb begin
      nxt   = redirect ? tgt : pc_plus4;
      pc_d  = stall ? pc_q : {nxt[31:2], 2'b00};
      err_d = err_q | (~stall & (|nxt[1:0]));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign pc_link = pc_plus4;
`endif
   assign pc        = pc_q;
   assign addr_err  = err_q;
   assign instr_cnt = cnt_q;
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  when 1, hold all state this cycle.
REQ-005 npc_sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump (imm26), 11 register (jr).
REQ-006 br_taken  in  1  branch condition result, qualified by npc_sel=01.
REQ-007 imm16  in  16  branch offset in words, signed.
REQ-008 imm26  in  26  jump target field.
REQ-009 ra  in  32  register jump target.
REQ-010 pc  out  32  current fetch address, driven to instruction memory.
REQ-011 pc_link  out  32  link value for jal/jalr.
REQ-012 addr_err  out  1  sticky misaligned-target flag.
REQ-013 instr_cnt  out  32  count of PC advances since reset.

Function
REQ-014 pc, instr_cnt and internal state SHALL update only on the rising clk edge with reset=0 and stall=0.
REQ-015 Sequential target SHALL be pc+4, modulo 2^32.
REQ-016 Branch target SHALL be pc+4 + (sign-extended imm16 << 2) when br_taken=1; pc+4 when br_taken=0.
REQ-017 Jump target SHALL be {pc_plus4[31:28], imm26, 2'b00}.
REQ-018 Register target SHALL be ra.
REQ-019 A target with bits [1:0] != 0 SHALL load {target[31:2], 2'b00} into pc and set addr_err, which stays 1 until reset.
REQ-020 instr_cnt SHALL increment by 1 per non-stalled cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-021 With stall=1, pc, instr_cnt, addr_err and the delay-slot state SHALL hold; control inputs are re-sampled on the first non-stalled cycle.
REQ-022 pc and pc_link SHALL be combinational from registered state only; no combinational path from npc_sel, br_taken, imm16, imm26 or ra to pc.
REQ-023 Without delay slots, a redirect SHALL take effect on the edge that samples it (zero-bubble) and pc_link SHALL be pc+4.

Reset
REQ-024 On reset: pc=RESET_PC, instr_cnt=0, addr_err=0, delay-slot state=IDLE, pending target cleared.
REQ-025 Reset SHALL take priority over stall.
REQ-026 Reset in the SLOT state SHALL discard the pending target.

Configuration
REQ-027 Macro IFU_DELAY_SLOT_EN SHALL enable MIPS branch-delay-slot semantics; when undefined, REQ-023 applies and no slot state exists.
REQ-028 With IFU_DELAY_SLOT_EN, two-state FSM IDLE/SLOT: in IDLE, a taken redirect (branch taken, jump or jr) loads pc<=pc+4, latches the target and moves to SLOT; non-redirect stays IDLE.
REQ-029 With IFU_DELAY_SLOT_EN, in SLOT the next advance loads pc<=latched target and returns to IDLE; npc_sel in the slot instruction SHALL be ignored.
REQ-030 With IFU_DELAY_SLOT_EN, pc_link SHALL be pc+8, and the alignment check SHALL apply when the target is latched.

Verification
REQ-031 Reset, 3 unstalled cycles npc_sel=00 -> pc 0x3000, 0x3004, 0x3008, 0x300C; instr_cnt 0..3.
REQ-032 pc=0x3004, npc_sel=01, br_taken=1, imm16=0xFFFF -> pc=0x3004 next edge; br_taken=0 -> pc=0x3008.
REQ-033 pc=0x3000, npc_sel=10, imm26=0x0000C03 -> pc=0x0000300C; pc_link=0x3004 (0x3008 with IFU_DELAY_SLOT_EN).
REQ-034 npc_sel=11, ra=0x3002 -> pc=0x3000, addr_err=1, and addr_err stays 1 through 10 sequential cycles until reset.
REQ-035 IFU_DELAY_SLOT_EN: pc=0x3000 branch taken imm16=3 -> pc 0x3004, then 0x3010; a stall held 2 cycles in SLOT keeps pc=0x3004 and instr_cnt constant; reset in SLOT -> pc=0x3000, next pc=0x3004.
